// File: rtl/noise_run_ctrl.sv
`timescale 1ns/1ps
// Run sequencer for random_noise: streams the probability table into the generator,
// terminates it, then counts valid and out-of-threshold samples up to a target.
module noise_run_ctrl #(
  parameter int NOISE_RESOLUTION = 7,
  parameter int TABLE_DEPTH      = 64,
  parameter int PROB_WIDTH       = 64,
  parameter int CNT_WIDTH        = 64
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic                               abort,
  input  logic [CNT_WIDTH-1:0]               sample_target,
  input  logic signed [NOISE_RESOLUTION-1:0] thresh_hi,
  input  logic signed [NOISE_RESOLUTION-1:0] thresh_lo,
  output logic [$clog2(TABLE_DEPTH)-1:0]     tbl_addr,
  input  logic [PROB_WIDTH-1:0]              tbl_data,
  output logic [PROB_WIDTH-1:0]              noise_prob,
  output logic [31:0]                        noise_prob_idx,
  output logic                               noise_en,
  output logic                               noise_rstn,
  input  logic signed [NOISE_RESOLUTION-1:0] noise_in,
  input  logic                               noise_valid,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_WIDTH-1:0]               bit_count,
  output logic [CNT_WIDTH-1:0]               err_count
);

  localparam int AW = $clog2(TABLE_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TERM, S_RUN, S_FINISH} state_t;

  state_t                              r_state, w_state_nxt;
  logic [AW-1:0]                       r_tbl_addr;
  logic [AW:0]                         r_lcnt;
  logic [PROB_WIDTH-1:0]               r_prob;
  logic [31:0]                         r_idx;
  logic                                r_en, r_nrstn, r_busy, r_done;
  logic [CNT_WIDTH-1:0]                r_bit_count, r_err_count, r_target;
  logic signed [NOISE_RESOLUTION-1:0]  r_thresh_hi, r_thresh_lo;

  logic                                w_hit, w_err, w_last, w_load_last;
  logic [CNT_WIDTH-1:0]                w_bit_inc;

  always_comb begin
    w_bit_inc   = r_bit_count + 1'b1;
    w_hit       = (r_state == S_RUN) && noise_valid;
    w_err       = (noise_in > r_thresh_hi) || (noise_in < r_thresh_lo);
    w_last      = w_hit && (w_bit_inc == r_target);
    // r_lcnt runs one ahead of the returned entry; DEPTH+1 means the last entry is out
    w_load_last = (int'(r_lcnt) == TABLE_DEPTH + 1);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   if (abort) w_state_nxt = S_IDLE;
                else if (w_load_last) w_state_nxt = S_TERM;
      S_TERM:   if (abort) w_state_nxt = S_IDLE;
                else if (r_target == '0) w_state_nxt = S_FINISH;
                else w_state_nxt = S_RUN;
      S_RUN:    if (abort) w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are registered on the edge that enters the state they belong to
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tbl_addr  <= '0;
      r_lcnt      <= '0;
      r_prob      <= '0;
      r_idx       <= '1;
      r_en        <= 1'b0;
      r_nrstn     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bit_count <= '0;
      r_err_count <= '0;
      r_target    <= '0;
      r_thresh_hi <= '0;
      r_thresh_lo <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_target    <= sample_target;
          r_thresh_hi <= thresh_hi;
          r_thresh_lo <= thresh_lo;
          r_bit_count <= '0;
          r_err_count <= '0;
          r_tbl_addr  <= '0;
          r_lcnt      <= '0;
          r_busy      <= 1'b1;
        end
        S_LOAD: if (abort) begin
          r_busy <= 1'b0;
          r_idx  <= '1;
        end else begin
          r_lcnt <= r_lcnt + 1'b1;
          if (int'(r_tbl_addr) != TABLE_DEPTH - 1) r_tbl_addr <= r_tbl_addr + 1'b1;
          if (r_lcnt != '0 && int'(r_lcnt) <= TABLE_DEPTH) begin
            r_prob <= tbl_data;
            r_idx  <= 32'(r_lcnt - 1'b1);
          end
          if (w_load_last) r_idx <= '1;
        end
        S_TERM: if (abort) begin
          r_busy <= 1'b0;
        end else if (r_target == '0) begin
          r_done <= 1'b1;
        end else begin
          r_en    <= 1'b1;
          r_nrstn <= 1'b1;
        end
        S_RUN: if (abort) begin
          r_en    <= 1'b0;
          r_nrstn <= 1'b0;
          r_busy  <= 1'b0;
        end else if (w_hit) begin
          r_bit_count <= w_bit_inc;
          if (w_err) r_err_count <= r_err_count + 1'b1;
          if (w_last) begin
            r_done  <= 1'b1;
            r_en    <= 1'b0;
            r_nrstn <= 1'b0;
          end
        end
        S_FINISH: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign tbl_addr       = r_tbl_addr;
  assign noise_prob     = r_prob;
  assign noise_prob_idx = r_idx;
  assign noise_en       = r_en;
  assign noise_rstn     = r_nrstn;
  assign busy           = r_busy;
  assign done           = r_done;
  assign bit_count      = r_bit_count;
  assign err_count      = r_err_count;

endmodule

// File: tb/tb_noise_run_ctrl.sv
`timescale 1ns/1ps
// Bench for noise_run_ctrl: timeline model of a run (offsets from the start edge)
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_noise_run_ctrl;
  localparam int NR = 7, TD = 64, PW = 64, CW = 64;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, noise_valid = 1'b0;
  logic [CW-1:0] sample_target = '0;
  logic signed [NR-1:0] thresh_hi = '0, thresh_lo = '0, noise_in = '0;
  logic [5:0] tbl_addr;
  logic [PW-1:0] tbl_data = '0;
  logic [PW-1:0] noise_prob;
  logic [31:0] noise_prob_idx;
  logic noise_en, noise_rstn, busy, done;
  logic [CW-1:0] bit_count, err_count;

  logic [PW-1:0] mem [TD];
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;

  noise_run_ctrl #(.NOISE_RESOLUTION(NR), .TABLE_DEPTH(TD), .PROB_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .sample_target(sample_target),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .noise_prob(noise_prob), .noise_prob_idx(noise_prob_idx), .noise_en(noise_en),
    .noise_rstn(noise_rstn), .noise_in(noise_in), .noise_valid(noise_valid), .busy(busy),
    .done(done), .bit_count(bit_count), .err_count(err_count));

  always #5 clk = ~clk;
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts edges since the accepted start.
  logic [PW-1:0] m_prob = '0;
  logic [31:0] m_idx = 32'hFFFFFFFF;
  logic [5:0] m_addr = '0;
  logic m_en = 0, m_nrstn = 0, m_busy = 0, m_done = 0;
  logic [CW-1:0] m_bits = '0, m_errs = '0, m_target = '0;
  logic signed [NR-1:0] m_hi = '0, m_lo = '0;
  bit m_run = 0, m_fin = 0;
  int m_t = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_prob = '0; m_idx = 32'hFFFFFFFF; m_addr = '0; m_en = 0; m_nrstn = 0;
      m_busy = 0; m_done = 0; m_bits = '0; m_errs = '0; m_run = 0; m_fin = 0;
    end else if (m_fin) begin
      m_fin = 0; m_run = 0; m_done = 0; m_busy = 0;
    end else if (!m_run) begin
      if (start) begin
        m_target = sample_target; m_hi = thresh_hi; m_lo = thresh_lo;
        m_bits = '0; m_errs = '0; m_addr = '0; m_busy = 1; m_run = 1; m_t = 0;
      end
    end else begin
      m_t++;
      if (abort) begin
        m_run = 0; m_busy = 0; m_en = 0; m_nrstn = 0; m_idx = 32'hFFFFFFFF;
      end else begin
        if (m_t >= 1 && m_t <= TD - 1) m_addr = 6'(m_t);
        if (m_t >= 2 && m_t <= TD + 1) begin m_prob = mem[m_t - 2]; m_idx = 32'(m_t - 2); end
        if (m_t == TD + 2) m_idx = 32'hFFFFFFFF;
        if (m_t == TD + 3) begin
          if (m_target == 0) begin m_done = 1; m_fin = 1; end
          else begin m_en = 1; m_nrstn = 1; end
        end
        if (m_t >= TD + 4 && noise_valid) begin
          m_bits++;
          if (noise_in > m_hi || noise_in < m_lo) m_errs++;
          if (m_bits == m_target) begin m_done = 1; m_en = 0; m_nrstn = 0; m_fin = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_tbl_addr", 64'(tbl_addr), 64'(m_addr));
      chk("cyc_noise_prob", noise_prob, m_prob);
      chk("cyc_prob_idx", 64'(noise_prob_idx), 64'(m_idx));
      chk("cyc_noise_en", 64'(noise_en), 64'(m_en));
      chk("cyc_noise_rstn", 64'(noise_rstn), 64'(m_nrstn));
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_bit_count", bit_count, m_bits);
      chk("cyc_err_count", err_count, m_errs);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [CW-1:0] tgt, input int hi, input int lo);
    sample_target = tgt; thresh_hi = 7'(hi); thresh_lo = 7'(lo);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!noise_en && n < 200) begin tick(); n++; end
    chk(name, 64'(noise_en), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int samples [40];
    int pool [7] = '{24, -23, 0, -1, 23, -22, 12};
    int n;
    bit en_seen;
    for (int k = 0; k < TD; k++) mem[k] = 64'(k) * 64'h0101;
    chk_on = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("rst_idx", 64'(noise_prob_idx), 64'hFFFFFFFF);
    chk("rst_busy", 64'(busy), 64'd0);

    // Table ramp, then 10 samples and an abort
    do_start(1000, 24, -23);
    tick(); tick();
    chk("ramp_prob0", noise_prob, 64'h0);
    chk("ramp_idx0", 64'(noise_prob_idx), 64'd0);
    tick();
    chk("ramp_prob1", noise_prob, 64'h0101);
    chk("ramp_idx1", 64'(noise_prob_idx), 64'd1);
    repeat (62) tick();
    chk("ramp_prob63", noise_prob, 64'h3F3F);
    chk("ramp_idx63", 64'(noise_prob_idx), 64'd63);
    tick();
    chk("ramp_term", 64'(noise_prob_idx), 64'hFFFFFFFF);
    chk("ramp_en66", 64'(noise_en), 64'd0);
    tick();
    chk("ramp_en67", 64'(noise_en), 64'd1);
    chk("ramp_rstn67", 64'(noise_rstn), 64'd1);
    for (int i = 0; i < 10; i++) begin
      noise_valid = 1'b1; noise_in = 7'($urandom); tick();
    end
    noise_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bits", bit_count, 64'd10);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_en", 64'(noise_en), 64'd0);
    tick();
    chk("abort_done2", 64'(done), 64'd0);

    // Known 40-sample stream, 5 errors, boundary values included; start while busy
    for (int i = 0; i < 40; i++) samples[i] = pool[i % 7];
    samples[3] = 25; samples[11] = -24; samples[19] = 25; samples[27] = -24; samples[35] = 25;
    do_start(40, 24, -23);
    start = 1'b1; sample_target = 5; repeat (3) tick(); start = 1'b0;
    wait_en("run40_en");
    for (int i = 0; i < 40; i++) begin
      if (i % 7 == 3) begin noise_valid = 1'b0; noise_in = 7'(25); tick(); end
      noise_valid = 1'b1; noise_in = 7'(samples[i]); tick();
    end
    noise_valid = 1'b0;
    chk("run40_done", 64'(done), 64'd1);
    chk("run40_bits", bit_count, 64'd40);
    chk("run40_errs", err_count, 64'd5);
    chk("run40_busy", 64'(busy), 64'd1);
    chk("run40_en_off", 64'(noise_en), 64'd0);
    tick();
    chk("run40_done_off", 64'(done), 64'd0);
    chk("run40_idle", 64'(busy), 64'd0);

    // Target 0, with valid asserted throughout (must be ignored)
    tick();
    noise_valid = 1'b1;
    do_start(0, 24, -23);
    n = 0; en_seen = 1'b0;
    while (!done && n < 100) begin tick(); n++; if (noise_en) en_seen = 1'b1; end
    noise_valid = 1'b0;
    chk("t0_latency", 64'(n), 64'd67);
    chk("t0_en_seen", 64'(en_seen), 64'd0);
    chk("t0_bits", bit_count, 64'd0);
    chk("t0_errs", err_count, 64'd0);
    tick();

    // Reset asserted mid-LOAD
    do_start(100, 10, -10);
    repeat (20) tick();
    #1 rstn = 1'b0;
    #4;
    chk("rstld_addr", 64'(tbl_addr), 64'd0);
    chk("rstld_prob", noise_prob, 64'd0);
    chk("rstld_idx", 64'(noise_prob_idx), 64'hFFFFFFFF);
    chk("rstld_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    tick();

    // Randomized runs
    for (int r = 0; r < 15; r++) begin
      int cyc, dens;
      bit do_ab;
      for (int k = 0; k < TD; k++) mem[k] = {$urandom, $urandom};
      dens = int'($urandom_range(1, 4));
      do_ab = (r % 4 == 1);
      do_start((r == 3) ? 64'd0 : 64'($urandom_range(1, 40)),
               int'($urandom_range(0, 30)), -int'($urandom_range(0, 30)));
      cyc = 0;
      while (busy && cyc < 500) begin
        noise_valid   = ($urandom_range(0, dens) != 0);
        noise_in      = 7'($urandom);
        abort         = do_ab && ($urandom_range(0, 99) == 0);
        start         = (cyc < 60) && ($urandom_range(0, 15) == 0);
        sample_target = 64'($urandom);
        thresh_hi     = 7'($urandom);
        thresh_lo     = 7'($urandom);
        tick();
        cyc++;
      end
      start = 1'b0; abort = 1'b0; noise_valid = 1'b0;
      chk("rand_idle", 64'(busy), 64'd0);
      tick(); tick();
    end

    repeat (3) tick();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
